// File: rtl/bitfuscnn_pkg.sv
// ---------------------------------------------------------------------------
// bitfuscnn_pkg
//   Shared types and helpers for the sparse activation path: encoder state,
//   the (value, zero-run index) entry layout stored in OARAM, and the
//   run-length saturation helper used by encoder and decompressor alike.
// ---------------------------------------------------------------------------
package bitfuscnn_pkg;

   localparam int VALUE_WIDTH_DEF = 8;
   localparam int INDEX_WIDTH_DEF = 4;
   localparam int RAM_WIDTH_DEF   = 10;
   localparam int STAT_WIDTH      = 16;

   typedef enum logic [1:0] {
      ENCODE = 2'd0,
      DONE   = 2'd1,
      FULL   = 2'd2
   } encoder_state_t;

   // One OARAM word as seen by the next layer's input fetch.
   typedef struct packed {
      logic [VALUE_WIDTH_DEF-1:0] value;
      logic [INDEX_WIDTH_DEF-1:0] index;
   } sparse_entry_t;

   // Longest zero run a single index field can express.
   function automatic int max_run(input int index_width);
      return (1 << index_width) - 1;
   endfunction

endpackage

// File: rtl/sparse_output_encoder_zero_run_counter.sv
// ---------------------------------------------------------------------------
// zero_run_counter
//   Tracks the number of zeros seen since the last emitted entry and decides
//   when a beat must produce an OARAM write: every nonzero value, and every
//   zero that arrives while the run is already saturated (a saturation entry
//   standing for MAX_RUN+1 zeros). in_last-style termination drops whatever
//   trailing run is left.
//
// Ports
//   clk, reset   clock, asynchronous active-high reset
//   clear        synchronous run clear
//   accept_i     a beat is consumed this cycle
//   zero_i       the consumed beat is zero
//   last_i       the consumed beat ends the group
//   run_o        zeros preceding the current beat (index field to write)
//   write_req_o  the current beat produces an entry
// ---------------------------------------------------------------------------
module zero_run_counter
   import bitfuscnn_pkg::*;
#(
   parameter int INDEX_WIDTH = INDEX_WIDTH_DEF
) (
   input  logic                   clk,
   input  logic                   reset,
   input  logic                   clear,
   input  logic                   accept_i,
   input  logic                   zero_i,
   input  logic                   last_i,
   output logic [INDEX_WIDTH-1:0] run_o,
   output logic                   write_req_o
);

   localparam logic [INDEX_WIDTH-1:0] MAX_RUN = INDEX_WIDTH'(max_run(INDEX_WIDTH));
   localparam logic [INDEX_WIDTH-1:0] RUN_ONE = 1;

   logic [INDEX_WIDTH-1:0] run_q, run_d;
   logic                   sat;

   assign sat   = (run_q == MAX_RUN);
   assign run_o = run_q;

   always_comb begin
      run_d       = run_q;
      write_req_o = 1'b0;
      if (accept_i) begin
         if (!zero_i) begin
            write_req_o = 1'b1;
            run_d       = '0;
         end else if (sat) begin
            // saturation entry (0, MAX_RUN) absorbs this zero as well
            write_req_o = 1'b1;
            run_d       = '0;
         end else begin
            run_d = run_q + RUN_ONE;
         end
         // trailing zeros of a group are never written
         if (last_i) run_d = '0;
      end
      if (clear) run_d = '0;
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) run_q <= '0;
      else       run_q <= run_d;
   end

endmodule

// File: rtl/sparse_output_encoder.sv
// ---------------------------------------------------------------------------
// sparse_output_encoder
//   Converts a dense, raster-ordered stream of post-ReLU activations into
//   (value, zero-run) entries written to consecutive OARAM addresses.
//   Saturated runs emit (0, MAX_RUN) saturation entries, trailing zeros at
//   in_last are dropped, and a full OARAM stalls the stream until clear.
//
// Ports
//   clk, reset            clock, asynchronous active-high reset
//   clear                 synchronous new-layer restart (ptr, run, counts)
//   in_valid/in_value/in_last/in_ready   dense activation stream
//   oaram_value, oaram_indices_value, oaram_address, oaram_write_enable
//                         registered OARAM write port
//   oaram_full            OARAM exhausted, waiting for clear
//   group_done            one-cycle pulse after a group is fully encoded
//   group_entry_count     entries written for the last completed group
//
// Optional build: define SPARSE_ENC_STATS_EN to add saturating counters of
//   saturation entries written and trailing zeros dropped.
// ---------------------------------------------------------------------------
module sparse_output_encoder
   import bitfuscnn_pkg::*;
#(
   parameter int VALUE_WIDTH = VALUE_WIDTH_DEF,
   parameter int INDEX_WIDTH = INDEX_WIDTH_DEF,
   parameter int RAM_WIDTH   = RAM_WIDTH_DEF
) (
   input  logic                   clk,
   input  logic                   reset,
   input  logic                   clear,
   input  logic                   in_valid,
   input  logic [VALUE_WIDTH-1:0] in_value,
   input  logic                   in_last,
   output logic                   in_ready,
   output logic [VALUE_WIDTH-1:0] oaram_value,
   output logic [INDEX_WIDTH-1:0] oaram_indices_value,
   output logic [RAM_WIDTH-1:0]   oaram_address,
   output logic                   oaram_write_enable,
   output logic                   oaram_full,
   output logic                   group_done,
   output logic [RAM_WIDTH:0]     group_entry_count
`ifdef SPARSE_ENC_STATS_EN
   ,
   output logic [STAT_WIDTH-1:0]  placeholder_count,
   output logic [STAT_WIDTH-1:0]  dropped_zero_count
`endif
);

   localparam logic [RAM_WIDTH:0]   CNT_ONE   = 1;
   localparam logic [RAM_WIDTH-1:0] LAST_ADDR = '1;

   encoder_state_t state_q, state_d;

   // wr_ptr_q carries one extra bit so a wrap past the last address is
   // remembered instead of silently reusing address 0.
   logic [RAM_WIDTH:0]     wr_ptr_q, wr_ptr_d;
   logic [RAM_WIDTH:0]     entry_cnt_q, entry_cnt_d;
   logic [RAM_WIDTH:0]     grp_cnt_q, grp_cnt_d;
   logic [VALUE_WIDTH-1:0] value_q;
   logic [INDEX_WIDTH-1:0] index_q;
   logic [RAM_WIDTH-1:0]   addr_q;
   logic                   wen_q;

   logic                   accept;
   logic                   in_zero;
   logic                   write_req;
   logic                   at_last_addr;
   logic [INDEX_WIDTH-1:0] run;

   // in_ready depends only on state, clear and reset, never on in_valid.
   assign in_ready     = (state_q == ENCODE) && !clear && !reset;
   assign accept       = in_valid && in_ready;
   assign in_zero      = (in_value == '0);
   assign at_last_addr = (wr_ptr_q[RAM_WIDTH-1:0] == LAST_ADDR);

   zero_run_counter #(
      .INDEX_WIDTH (INDEX_WIDTH)
   ) u_run (
      .clk         (clk),
      .reset       (reset),
      .clear       (clear),
      .accept_i    (accept),
      .zero_i      (in_zero),
      .last_i      (in_last),
      .run_o       (run),
      .write_req_o (write_req)
   );

   // ---------------- FSM: state register ----------------
   always_ff @(posedge clk or posedge reset) begin
      if (reset) state_q <= ENCODE;
      else       state_q <= state_d;
   end

   // ---------------- FSM: next state ----------------
   always_comb begin
      state_d = state_q;
      unique case (state_q)
         ENCODE: begin
            if (accept && in_last)              state_d = DONE;
            else if (write_req && at_last_addr) state_d = FULL;
         end
         // a group whose last write hit the final address still reports
         // done first, then parks in FULL
         DONE:    state_d = wr_ptr_q[RAM_WIDTH] ? FULL : ENCODE;
         FULL:    state_d = FULL;
         default: state_d = ENCODE;
      endcase
      if (clear) state_d = ENCODE;
   end

   // ---------------- FSM: outputs ----------------
   always_comb begin
      group_done = (state_q == DONE) && !clear;
      oaram_full = (state_q == FULL);
   end

   // ---------------- pointer and counters ----------------
   always_comb begin
      wr_ptr_d    = wr_ptr_q;
      entry_cnt_d = entry_cnt_q;
      grp_cnt_d   = grp_cnt_q;
      if (clear) begin
         wr_ptr_d    = '0;
         entry_cnt_d = '0;
      end else begin
         if (write_req) wr_ptr_d = wr_ptr_q + CNT_ONE;
         // no writes can occur in DONE, so the count is final here
         if (state_q == DONE) begin
            grp_cnt_d   = entry_cnt_q;
            entry_cnt_d = '0;
         end else if (write_req) begin
            entry_cnt_d = entry_cnt_q + CNT_ONE;
         end
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         wr_ptr_q    <= '0;
         entry_cnt_q <= '0;
         grp_cnt_q   <= '0;
         value_q     <= '0;
         index_q     <= '0;
         addr_q      <= '0;
         wen_q       <= 1'b0;
      end else begin
         wr_ptr_q    <= wr_ptr_d;
         entry_cnt_q <= entry_cnt_d;
         grp_cnt_q   <= grp_cnt_d;
         wen_q       <= write_req;
         if (write_req) begin
            value_q <= in_value;  // zero for saturation entries
            index_q <= run;
            addr_q  <= wr_ptr_q[RAM_WIDTH-1:0];
         end
      end
   end

   assign oaram_value         = value_q;
   assign oaram_indices_value = index_q;
   assign oaram_address       = addr_q;
   assign oaram_write_enable  = wen_q;
   assign group_entry_count   = grp_cnt_q;

`ifdef SPARSE_ENC_STATS_EN
   localparam logic [INDEX_WIDTH-1:0] MAX_RUN = INDEX_WIDTH'(max_run(INDEX_WIDTH));
   localparam logic [STAT_WIDTH:0]    STAT_ONE = 1;

   logic [STAT_WIDTH-1:0] plc_cnt_q, plc_cnt_d;
   logic [STAT_WIDTH-1:0] drop_cnt_q, drop_cnt_d;
   logic [STAT_WIDTH:0]   plc_sum, drop_sum;
   logic                  plc_evt, drop_evt;

   assign plc_evt  = write_req && in_zero;
   // a saturated zero at in_last becomes a saturation entry, so nothing drops
   assign drop_evt = accept && in_last && in_zero && (run != MAX_RUN);
   assign plc_sum  = {1'b0, plc_cnt_q} + STAT_ONE;
   assign drop_sum = {1'b0, drop_cnt_q} + (STAT_WIDTH+1)'(run) + STAT_ONE;

   always_comb begin
      plc_cnt_d  = plc_cnt_q;
      drop_cnt_d = drop_cnt_q;
      if (clear) begin
         plc_cnt_d  = '0;
         drop_cnt_d = '0;
      end else begin
         if (plc_evt)  plc_cnt_d  = plc_sum[STAT_WIDTH]  ? '1 : plc_sum[STAT_WIDTH-1:0];
         if (drop_evt) drop_cnt_d = drop_sum[STAT_WIDTH] ? '1 : drop_sum[STAT_WIDTH-1:0];
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         plc_cnt_q  <= '0;
         drop_cnt_q <= '0;
      end else begin
         plc_cnt_q  <= plc_cnt_d;
         drop_cnt_q <= drop_cnt_d;
      end
   end

   assign placeholder_count  = plc_cnt_q;
   assign dropped_zero_count = drop_cnt_q;
`endif

endmodule
